// File: rtl/rtc_pkg.sv
// Shared types, BCD limits and field validation for the RTC timekeeping controller.
package rtc_pkg;

    typedef enum logic [2:0] {
        RESET,
        RUN,
        VALIDATE,
        HOLD,
        ACK
    } state_e;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

    // A field is acceptable when both nibbles are decimal digits and the value
    // does not exceed its limit (BCD compares correctly as binary once digits are legal).
    function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max_val);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max_val);
    endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// Two-digit BCD counter: load has priority over increment, wraps to 00 after max_i
// and reports a carry in the cycle the wrap is taken.
module bcd_digit_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] max_i,
    output logic [7:0] val_o,
    output logic       carry_o
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    assign val_o   = val_q;
    assign carry_o = inc_i && !load_i && (val_q == max_i);

    // Next value: load, wrap at max, low-digit rollover, or plain low-digit increment.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (inc_i) begin
            if (val_q == max_i) begin
                val_d = 8'h00;
            end else if (val_q[3:0] == 4'd9) begin
                val_d = {val_q[7:4] + 4'd1, 4'h0};
            end else begin
                val_d = {val_q[7:4], val_q[3:0] + 4'd1};
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= 8'h00;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/rtc_ctrl.sv
// RTC timekeeping controller: BCD hh:mm:ss driven by the 1 Hz tick, host time-set
// handshake that holds the divider in reset while loading, and an oscillator stall monitor.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_ctrl
    import rtc_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int STALL_LIMIT = 12000000,
    parameter int STALL_W     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz,
    input  logic       run_en,
    input  logic       set_req,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hr,
`ifdef RTC_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_min,
    input  logic [7:0] alarm_hr,
    input  logic       alarm_clr,
    output logic       alarm,
`endif
    output logic       set_ack,
    output logic       set_err,
    output logic       div_rst,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hr,
    output logic       time_valid,
    output logic       osc_fail
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_e              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                armed_q;
    logic                set_ack_q;
    logic                set_err_q;
    logic                div_rst_q;
    logic                time_valid_q;
    logic                osc_fail_q;
    logic [STALL_W-1:0]  stall_q;
    logic [STALL_W-1:0]  stall_d;
    logic [7:0]          ld_sec_q;
    logic [7:0]          ld_min_q;
    logic [7:0]          ld_hr_q;
    logic [7:0]          sec_q;
    logic [7:0]          min_q;
    logic [7:0]          hr_q;
    logic                tick_adv;
    logic                load_time;
    logic                fields_ok;
    logic                sec_carry;
    logic                min_carry;
    logic                hr_carry_unused;

    // Ticks only count in RUN; the first HOLD cycle commits the staged time.
    assign tick_adv  = (state_q == RUN) && one_hz && run_en;
    assign load_time = (state_q == HOLD) && (hold_cnt_q == '0);
    assign fields_ok = bcd_valid(set_sec, SEC_MAX) && bcd_valid(set_min, MIN_MAX) &&
                       bcd_valid(set_hr, HR_MAX);

    // Handshake FSM with registered set_ack/set_err/div_rst/time_valid.
    // armed_q blocks a second set until the host has dropped set_req for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET;
            hold_cnt_q   <= '0;
            armed_q      <= 1'b1;
            set_ack_q    <= 1'b0;
            set_err_q    <= 1'b0;
            div_rst_q    <= 1'b1;
            time_valid_q <= 1'b0;
        end else begin
            set_ack_q <= 1'b0;
            set_err_q <= 1'b0;
            if (!set_req) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                RESET: begin
                    state_q   <= RUN;
                    div_rst_q <= 1'b0;
                end
                RUN: begin
                    if (set_req && armed_q) begin
                        state_q <= VALIDATE;
                        armed_q <= 1'b0;
                    end
                end
                VALIDATE: begin
                    if (fields_ok) begin
                        state_q    <= HOLD;
                        div_rst_q  <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        state_q   <= ACK;
                        set_ack_q <= 1'b1;
                        set_err_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (load_time) begin
                        time_valid_q <= 1'b1;
                    end
                    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_q   <= ACK;
                        div_rst_q <= 1'b0;
                        set_ack_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q   <= RESET;
                    div_rst_q <= 1'b1;
                end
            endcase
        end
    end

    // Stage the requested time when it is validated so the load uses the checked values.
    always_ff @(posedge clk) begin
        if (state_q == VALIDATE) begin
            ld_sec_q <= set_sec;
            ld_min_q <= set_min;
            ld_hr_q  <= set_hr;
        end
    end

    // Stall counter: cleared by a tick or while the divider is held, saturates at the limit.
    always_comb begin
        stall_d = stall_q;
        if (div_rst_q || one_hz) begin
            stall_d = '0;
        end else if (stall_q != STALL_W'(STALL_LIMIT)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register and sticky oscillator-fail flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q    <= '0;
            osc_fail_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (stall_d == STALL_W'(STALL_LIMIT)) begin
                osc_fail_q <= 1'b1;
            end
        end
    end

    bcd_digit_ctr u_sec (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (tick_adv),
        .load_i     (load_time),
        .load_val_i (ld_sec_q),
        .max_i      (SEC_MAX),
        .val_o      (sec_q),
        .carry_o    (sec_carry)
    );

    bcd_digit_ctr u_min (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (sec_carry),
        .load_i     (load_time),
        .load_val_i (ld_min_q),
        .max_i      (MIN_MAX),
        .val_o      (min_q),
        .carry_o    (min_carry)
    );

    bcd_digit_ctr u_hr (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (min_carry),
        .load_i     (load_time),
        .load_val_i (ld_hr_q),
        .max_i      (HR_MAX),
        .val_o      (hr_q),
        .carry_o    (hr_carry_unused)
    );

`ifdef RTC_ALARM_EN
    logic       tick_adv_q;
    logic       alarm_q;
    logic [7:0] alarm_min_q;
    logic [7:0] alarm_hr_q;
    logic       alarm_match;

    // The time shown the cycle after an applied tick is compared; a match beats a clear.
    assign alarm_match = tick_adv_q && time_valid_q && (sec_q == 8'h00) &&
                         (min_q == alarm_min_q) && (hr_q == alarm_hr_q);
    assign alarm       = alarm_q;

    // Alarm compare registers and sticky alarm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_adv_q  <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_min_q <= 8'h00;
            alarm_hr_q  <= 8'h00;
        end else begin
            tick_adv_q <= tick_adv;
            if (alarm_set) begin
                alarm_min_q <= alarm_min;
                alarm_hr_q  <= alarm_hr;
            end
            if (alarm_match) begin
                alarm_q <= 1'b1;
            end else if (alarm_clr) begin
                alarm_q <= 1'b0;
            end
        end
    end
`else
    // Alarm comparator not built in this configuration.
`endif

    assign set_ack    = set_ack_q;
    assign set_err    = set_err_q;
    assign div_rst    = div_rst_q;
    assign sec        = sec_q;
    assign min        = min_q;
    assign hr         = hr_q;
    assign time_valid = time_valid_q;
    assign osc_fail   = osc_fail_q;

endmodule
